motor_throttle_sequencer: RTL and testbench
===========================================

# motor_throttle_sequencer

Sequencing and configuration controller for the four ESC PWM channels of the quadcopter. It owns ESC arming, per-channel throttle targets, slew limiting and command-loss failsafe. It presents one pulse width per channel, in clock cycles, plus a frame strobe; per-channel PWM generators consume these and only ever apply new widths at frame boundaries. It runs from the 53.20 MHz internal oscillator clock.

## Interface
- FRAME_CYCLES, 106_400: PWM frame length in clk cycles (2.0 ms).
- MIN_PW, 53_200: idle/arming pulse width (1.0 ms).
- MAX_PW, 103_200: maximum throttle pulse width.
- ARM_FRAMES, 100: frames held at MIN_PW before ARMED (200 ms).
- SLEW_STEP, 532: maximum per-frame change of any pulse width (10 µs).
- TIMEOUT_FRAMES, 50: frames without an accepted command before FAILSAFE (100 ms).
- clk  in  1  system clock. One clock domain.
- rst  in  1  reset. Synchronous, active-high.
- arm_req  in  1  request arming; level or pulse, sampled each cycle.
- disarm_req  in  1  request disarm; has priority over everything except rst.
- cmd_valid  in  1  throttle command valid.
- cmd_ch  in  2  target channel 0..3.
- cmd_pw  in  17  requested pulse width in cycles.
- cmd_ready  out  1  high iff state is ARMED.
- frame_start  out  1  one-cycle strobe at each frame boundary.
- pw_bus  out  68  channel n occupies bits [17n+16:17n]; 0 means no pulse.
- state  out  2  0 DISARMED, 1 ARMING, 2 ARMED, 3 FAILSAFE.
- failsafe  out  1  high iff state is FAILSAFE.

## Operation
- Reset values: state DISARMED, all pw 0, all targets MIN_PW, frame counter 0, frame_start 0, cmd_ready 0, failsafe 0, frame and timeout counters 0.
- Frame timer: the counter runs 0..FRAME_CYCLES-1 and wraps in every state. frame_start is registered high on the cycle after the wrap.
- DISARMED:
  - pw is 0.
  - arm_req (and no disarm_req) moves the block to ARMING.
- ARMING:
  - At each boundary, pw is set to MIN_PW.
  - Boundaries are counted.
  - On the ARM_FRAMES-th boundary, the block moves to ARMED and the timeout counter is cleared.
- ARMED:
  - A handshake occurs when cmd_valid && cmd_ready on a clock edge.
  - The accepted command writes target[cmd_ch] = clamp(cmd_pw, MIN_PW, MAX_PW).
  - At each boundary, each pw steps toward its target:
    - if |target−pw| ≤ SLEW_STEP, pw = target;
    - otherwise pw ± SLEW_STEP.
  - Arithmetic is 17-bit unsigned; the comparison is done before subtraction, so there is no underflow.
- Timeout (ARMED only):
  - The timeout counter increments at each boundary and clears on every accepted command.
  - If both happen on the same edge, the clear wins.
  - When it reaches TIMEOUT_FRAMES at a boundary, the block moves to FAILSAFE.
- FAILSAFE:
  - All targets are forced to MIN_PW; pw slews down at SLEW_STEP per boundary.
  - Commands are ignored (cmd_ready 0).
  - arm_req is ignored; the only exit is disarm_req.
- disarm_req in any state: next edge gives DISARMED and all pw 0 immediately, not at a boundary. All targets are reset to MIN_PW.
- arm_req and disarm_req on the same cycle: disarm wins.
- A command accepted on a boundary edge: the slew step on that edge uses the old target; the new target takes effect from the next boundary.

## Timing
- pw_bus changes only on an edge that asserts frame_start, except on disarm and rst, which take effect on the next edge.
- First frame_start is asserted FRAME_CYCLES cycles after rst deasserts. frame_start period is FRAME_CYCLES.
- State transitions triggered by a boundary occur on the edge that asserts frame_start. Outputs computed on that edge use the new state's rule.
- cmd_ready and failsafe are registered and decode state directly.
- Command to first pw change: ≤ FRAME_CYCLES+1 cycles.
- rst mid-operation: all outputs return to reset values on the next edge; the frame phase restarts at 0.

## Structure
- Package drone_pwm_pkg holds:
  - the state enum (DISARMED/ARMING/ARMED/FAILSAFE);
  - PW_W = 17 and NUM_CH = 4;
  - the default timing constants above, shared with the PWM generators.
- Sub-module frame_timer: frame counter and frame_start strobe, parameter FRAME_CYCLES. It is reused by the PWM generators for phase alignment.
- The top holds the FSM, the target registers, the clamp and the per-channel slew logic in a generate loop.

## Test plan
1. Arming: after rst, pulse arm_req.
   - pw stays 0 until the first frame_start, then all four channels are 53_200.
   - state becomes 2 on the 100th frame_start; cmd_ready rises with it.
2. Ramp: in ARMED, send cmd ch2 = 60_000.
   - pw2 reads 53_732 after 1 boundary, 59_584 after 12, 60_000 after 13.
   - Other channels stay at 53_200.
3. Clamp: cmd ch0 = 120_000 gives target 103_200; cmd ch1 = 10_000 gives target 53_200.
   - Verify the final pw values after slewing completes.
4. Failsafe: ramp ch3 to 56_000, then send no commands for 50 boundaries.
   - failsafe = 1; ch3 reads 55_468, 54_936, … down to 53_200.
   - cmd_ready = 0; arm_req has no effect.
   - disarm_req gives all pw 0 on the next edge.
5. Simultaneous events:
   - arm_req and disarm_req together in DISARMED: state stays 0.
   - A command on the frame_start edge: the change is applied at the following boundary.
   - A command on the timeout boundary: no FAILSAFE.
6. Reset mid-ramp: assert rst during a ch1 ramp.
   - Next edge: state 0, all pw 0, frame_start 0.
   - Next frame_start occurs 106_400 cycles after release.

Source files
------------

// File: rtl/drone_pwm_pkg.sv
// Shared types, timing defaults and pulse-width helpers for the ESC sequencer
// and the per-channel PWM generators.
package drone_pwm_pkg;

  localparam int unsigned PW_W   = 17;
  localparam int unsigned NUM_CH = 4;

  localparam int unsigned FRAME_CYCLES   = 106_400;
  localparam int unsigned MIN_PW         = 53_200;
  localparam int unsigned MAX_PW         = 103_200;
  localparam int unsigned ARM_FRAMES     = 100;
  localparam int unsigned SLEW_STEP      = 532;
  localparam int unsigned TIMEOUT_FRAMES = 50;

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArming   = 2'd1,
    StArmed    = 2'd2,
    StFailsafe = 2'd3
  } state_e;

  typedef logic [PW_W-1:0] pw_t;

  function automatic pw_t clamp_pw(input pw_t pw, input pw_t lo, input pw_t hi);
    pw_t r;
    if (pw < lo) r = lo;
    else if (pw > hi) r = hi;
    else r = pw;
    return r;
  endfunction

  // Distance is compared before subtracting so the unsigned step never wraps.
  function automatic pw_t slew_toward(input pw_t cur, input pw_t tgt, input pw_t step);
    pw_t r;
    if (tgt >= cur) r = (tgt - cur <= step) ? tgt : cur + step;
    else r = (cur - tgt <= step) ? tgt : cur - step;
    return r;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running PWM frame counter; wrap marks the boundary edge and frame_start
// is the registered strobe that follows it.
module frame_timer #(
  parameter int unsigned FRAME_CYCLES = drone_pwm_pkg::FRAME_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic wrap,
  output logic frame_start
);

  localparam int unsigned CntW = $clog2(FRAME_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            frame_start_q;

  assign wrap = (cnt_q == CntW'(FRAME_CYCLES - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= wrap;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: rtl/motor_throttle_sequencer.sv
// ESC arming, per-channel throttle targets, slew limiting and command-loss
// failsafe for the four quadcopter motor channels.
module motor_throttle_sequencer
  import drone_pwm_pkg::*;
#(
  parameter int unsigned FrameCycles   = FRAME_CYCLES,
  parameter int unsigned MinPw         = MIN_PW,
  parameter int unsigned MaxPw         = MAX_PW,
  parameter int unsigned ArmFrames     = ARM_FRAMES,
  parameter int unsigned SlewStep      = SLEW_STEP,
  parameter int unsigned TimeoutFrames = TIMEOUT_FRAMES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm_req,
  input  logic                     disarm_req,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_ch,
  input  logic [PW_W-1:0]          cmd_pw,
  output logic                     cmd_ready,
  output logic                     frame_start,
  output logic [NUM_CH*PW_W-1:0]   pw_bus,
  output logic [1:0]               state,
  output logic                     failsafe
);

  localparam int unsigned ArmW = $clog2(ArmFrames + 1);
  localparam int unsigned ToW  = $clog2(TimeoutFrames + 1);
  localparam pw_t MinPwT = PW_W'(MinPw);
  localparam pw_t MaxPwT = PW_W'(MaxPw);
  localparam pw_t SlewT  = PW_W'(SlewStep);

  state_e          state_q, state_d;
  logic [ArmW-1:0] arm_cnt_q, arm_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            failsafe_q, failsafe_d;
  logic            wrap;
  logic            accept;
  logic            arm_done;
  logic            to_expire;

  frame_timer #(
    .FRAME_CYCLES(FrameCycles)
  ) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .wrap       (wrap),
    .frame_start(frame_start)
  );

  assign accept    = cmd_valid && cmd_ready_q;
  assign arm_done  = (arm_cnt_q == ArmW'(ArmFrames - 1));
  assign to_expire = (to_cnt_q == ToW'(TimeoutFrames - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDisarmed;
      arm_cnt_q   <= '0;
      to_cnt_q    <= '0;
      cmd_ready_q <= 1'b0;
      failsafe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      failsafe_q  <= failsafe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (disarm_req) begin
      state_d = StDisarmed;
    end else begin
      case (state_q)
        StDisarmed: if (arm_req) state_d = StArming;
        StArming:   if (wrap && arm_done) state_d = StArmed;
        // An accepted command on the expiring boundary keeps the link alive.
        StArmed:    if (wrap && !accept && to_expire) state_d = StFailsafe;
        StFailsafe: state_d = StFailsafe;
        default:    state_d = StDisarmed;
      endcase
    end
  end

  always_comb begin
    arm_cnt_d = '0;
    to_cnt_d  = '0;
    if (state_q == StArming && state_d == StArming) begin
      arm_cnt_d = wrap ? arm_cnt_q + 1'b1 : arm_cnt_q;
    end
    if (state_q == StArmed && state_d == StArmed && !accept) begin
      to_cnt_d = wrap ? to_cnt_q + 1'b1 : to_cnt_q;
    end
  end

  always_comb begin
    cmd_ready_d = (state_d == StArmed);
    failsafe_d  = (state_d == StFailsafe);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pw_t pw_q, pw_d;
    pw_t tgt_q, tgt_d;
    pw_t slew_tgt;

    always_comb begin
      tgt_d = tgt_q;
      if (state_d == StDisarmed || state_d == StFailsafe) begin
        tgt_d = MinPwT;
      end else if (accept && cmd_ch == 2'(ch)) begin
        tgt_d = clamp_pw(cmd_pw, MinPwT, MaxPwT);
      end
    end

    // The step uses tgt_q, so a command landing on a boundary waits one frame.
    always_comb begin
      slew_tgt = (state_d == StFailsafe) ? MinPwT : tgt_q;
      pw_d     = pw_q;
      case (state_d)
        StDisarmed: pw_d = '0;
        StArming:   if (wrap) pw_d = MinPwT;
        default:    if (wrap) pw_d = slew_toward(pw_q, slew_tgt, SlewT);
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pw_q  <= '0;
        tgt_q <= MinPwT;
      end else begin
        pw_q  <= pw_d;
        tgt_q <= tgt_d;
      end
    end

    assign pw_bus[PW_W*ch +: PW_W] = pw_q;
  end

  assign cmd_ready = cmd_ready_q;
  assign failsafe  = failsafe_q;
  assign state     = state_q;

endmodule

// File: tb/tb_motor_throttle_sequencer.sv
// Self-checking bench: shortened frame timing, closed-form slew model per channel.
module tb_motor_throttle_sequencer;

  localparam int FC    = 16;
  localparam int AF    = 4;
  localparam int TF    = 100;
  localparam int MINPW = 53200;
  localparam int MAXPW = 103200;
  localparam int STEP  = 532;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm_req = 1'b0;
  logic        disarm_req = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_ch = 2'd0;
  logic [16:0] cmd_pw = 17'd0;
  logic        cmd_ready;
  logic        frame_start;
  logic [67:0] pw_bus;
  logic [1:0]  state;
  logic        failsafe;

  int checks = 0;
  int failures = 0;
  int exp_pw[4];
  int exp_tgt[4];

  motor_throttle_sequencer #(
    .FrameCycles  (FC),
    .MinPw        (MINPW),
    .MaxPw        (MAXPW),
    .ArmFrames    (AF),
    .SlewStep     (STEP),
    .TimeoutFrames(TF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm_req    (arm_req),
    .disarm_req (disarm_req),
    .cmd_valid  (cmd_valid),
    .cmd_ch     (cmd_ch),
    .cmd_pw     (cmd_pw),
    .cmd_ready  (cmd_ready),
    .frame_start(frame_start),
    .pw_bus     (pw_bus),
    .state      (state),
    .failsafe   (failsafe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int clampv(int v);
    if (v < MINPW) return MINPW;
    if (v > MAXPW) return MAXPW;
    return v;
  endfunction

  // Position after n boundaries moving from s toward t at STEP per boundary.
  function automatic int slew_after(int s, int t, int n);
    int d;
    int mv;
    d  = (t > s) ? t - s : s - t;
    mv = (n * STEP > d) ? d : n * STEP;
    return (t > s) ? s + mv : s - mv;
  endfunction

  function automatic logic [67:0] pack_exp();
    logic [67:0] v;
    for (int c = 0; c < 4; c++) v[17*c +: 17] = 17'(exp_pw[c]);
    return v;
  endfunction

  task automatic advance(int n);
    for (int c = 0; c < 4; c++) exp_pw[c] = slew_after(exp_pw[c], exp_tgt[c], n);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      exp_pw[c]  = 0;
      exp_tgt[c] = MINPW;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < FC + 2);
    checks++;
    if (!frame_start) begin
      failures++;
      $display("FAIL wait_frame: no frame_start within %0d cycles", n);
    end
  endtask

  task automatic send_cmd(int ch, int pw);
    cmd_valid = 1'b1;
    cmd_ch    = 2'(ch);
    cmd_pw    = 17'(pw);
    tick();
    cmd_valid = 1'b0;
    exp_tgt[ch] = clampv(pw);
  endtask

  // n boundaries; after each one optionally re-sends channel keep's target mid-frame.
  task automatic run_frames(int n, int keep);
    for (int i = 0; i < n; i++) begin
      wait_frame();
      advance(1);
      if (keep >= 0) send_cmd(keep, exp_tgt[keep]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    model_reset();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (pw_bus !== 68'd0) begin failures++; $display("FAIL rst_pw got=%h exp=0", pw_bus); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (failsafe !== 1'b0) begin failures++; $display("FAIL rst_failsafe got=%b exp=0", failsafe); end
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < FC + 5);
    checks++; if (n !== FC) begin failures++; $display("FAIL first_frame_start got=%0d exp=%0d", n, FC); end
    checks++; if (pw_bus !== 68'd0) begin failures++; $display("FAIL disarmed_pw got=%h exp=0", pw_bus); end
  endtask

  task automatic test_arming();
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL arm_enter got=%0d exp=1", state); end
    checks++; if (pw_bus !== 68'd0) begin failures++; $display("FAIL arm_pw_before_frame got=%h exp=0", pw_bus); end
    for (int c = 0; c < 4; c++) exp_pw[c] = MINPW;
    for (int f = 1; f <= AF; f++) begin
      wait_frame();
      checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL arm_pw f=%0d got=%h exp=%h", f, pw_bus, pack_exp()); end
      if (f < AF) begin
        checks++; if (state !== 2'd1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL arm_hold f=%0d state=%0d rdy=%b exp=1/0", f, state, cmd_ready); end
      end else begin
        checks++; if (state !== 2'd2 || cmd_ready !== 1'b1) begin failures++; $display("FAIL armed f=%0d state=%0d rdy=%b exp=2/1", f, state, cmd_ready); end
      end
    end
  endtask

  task automatic test_ramp();
    send_cmd(2, 60000);
    checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL ramp_midframe got=%h exp=%h", pw_bus, pack_exp()); end
    for (int k = 1; k <= 13; k++) begin
      wait_frame();
      advance(1);
      checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL ramp k=%0d got=%h exp=%h", k, pw_bus, pack_exp()); end
      if (k == 1) begin
        checks++; if (pw_bus[50:34] !== 17'd53732) begin failures++; $display("FAIL ramp_k1 got=%0d exp=53732", pw_bus[50:34]); end
      end else if (k == 12) begin
        checks++; if (pw_bus[50:34] !== 17'd59584) begin failures++; $display("FAIL ramp_k12 got=%0d exp=59584", pw_bus[50:34]); end
      end else if (k == 13) begin
        checks++; if (pw_bus[50:34] !== 17'd60000) begin failures++; $display("FAIL ramp_k13 got=%0d exp=60000", pw_bus[50:34]); end
      end
    end
  endtask

  task automatic test_clamp();
    send_cmd(0, 120000);
    send_cmd(1, 54000);
    run_frames(2, 0);
    checks++; if (pw_bus[33:17] !== 17'd54000) begin failures++; $display("FAIL clamp_ch1_up got=%0d exp=54000", pw_bus[33:17]); end
    send_cmd(1, 10000);
    run_frames(3, 1);
    checks++; if (pw_bus[33:17] !== 17'd53200) begin failures++; $display("FAIL clamp_low got=%0d exp=53200", pw_bus[33:17]); end
    run_frames(92, 0);
    checks++; if (pw_bus[16:0] !== 17'd103200) begin failures++; $display("FAIL clamp_high got=%0d exp=103200", pw_bus[16:0]); end
    checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL clamp_all got=%h exp=%h", pw_bus, pack_exp()); end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) send_cmd(c, int'($urandom_range(125000, 30000)));
      n = int'($urandom_range(25, 1));
      for (int i = 0; i < n; i++) begin
        run_frames(1, int'($urandom_range(3, 0)));
        checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL random r=%0d i=%0d got=%h exp=%h", r, i, pw_bus, pack_exp()); end
      end
    end
  endtask

  task automatic test_failsafe();
    int guard;
    send_cmd(3, 56000);
    guard = 0;
    while (exp_pw[3] != 56000 && guard < 300) begin
      run_frames(1, 3);
      guard++;
    end
    checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL fs_pre got=%h exp=%h", pw_bus, pack_exp()); end
    for (int b = 1; b <= TF; b++) begin
      wait_frame();
      if (b == TF) for (int c = 0; c < 4; c++) exp_tgt[c] = MINPW;
      advance(1);
      if (b == TF - 1) begin
        checks++; if (state !== 2'd2 || failsafe !== 1'b0) begin failures++; $display("FAIL fs_early state=%0d fs=%b exp=2/0", state, failsafe); end
      end
    end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL fs_state got=%0d exp=3", state); end
    checks++; if (failsafe !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL fs_flags fs=%b rdy=%b exp=1/0", failsafe, cmd_ready); end
    checks++; if (pw_bus[67:51] !== 17'd55468) begin failures++; $display("FAIL fs_ch3_1 got=%0d exp=55468", pw_bus[67:51]); end
    checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL fs_all got=%h exp=%h", pw_bus, pack_exp()); end
    wait_frame();
    advance(1);
    checks++; if (pw_bus[67:51] !== 17'd54936) begin failures++; $display("FAIL fs_ch3_2 got=%0d exp=54936", pw_bus[67:51]); end
    arm_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_ch = 2'd0;
    cmd_pw = 17'd110000;
    tick();
    tick();
    arm_req = 1'b0;
    cmd_valid = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL fs_arm_ignored got=%0d exp=3", state); end
    wait_frame();
    advance(1);
    checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL fs_cmd_ignored got=%h exp=%h", pw_bus, pack_exp()); end
    tick();
    tick();
    tick();
    disarm_req = 1'b1;
    tick();
    disarm_req = 1'b0;
    model_reset();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL disarm_state got=%0d exp=0", state); end
    checks++; if (pw_bus !== 68'd0) begin failures++; $display("FAIL disarm_pw got=%h exp=0", pw_bus); end
    checks++; if (failsafe !== 1'b0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL disarm_flags fs=%b rdy=%b exp=0/0", failsafe, cmd_ready); end
  endtask

  task automatic test_simultaneous();
    arm_req = 1'b1;
    disarm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    disarm_req = 1'b0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL arm_disarm got=%0d exp=0", state); end
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL arm_disarm_hold got=%0d exp=0", state); end
    wait_frame();
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    for (int f = 0; f < AF; f++) wait_frame();
    for (int c = 0; c < 4; c++) exp_pw[c] = MINPW;
    checks++; if (state !== 2'd2 || pw_bus !== pack_exp()) begin failures++; $display("FAIL rearm state=%0d pw=%h exp=2/%h", state, pw_bus, pack_exp()); end
    // Command sampled on the boundary edge itself.
    repeat (FC - 1) tick();
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL pre_boundary fs got=%b exp=0", frame_start); end
    cmd_valid = 1'b1;
    cmd_ch = 2'd1;
    cmd_pw = 17'd58000;
    tick();
    cmd_valid = 1'b0;
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL boundary_cmd fs got=%b exp=1", frame_start); end
    advance(1);
    exp_tgt[1] = 58000;
    checks++; if (pw_bus[33:17] !== 17'd53200) begin failures++; $display("FAIL boundary_cmd_old got=%0d exp=53200", pw_bus[33:17]); end
    wait_frame();
    advance(1);
    checks++; if (pw_bus[33:17] !== 17'd53732) begin failures++; $display("FAIL boundary_cmd_new got=%0d exp=53732", pw_bus[33:17]); end
    // Command arriving on the boundary that would otherwise expire the timeout.
    send_cmd(1, 58000);
    for (int b = 1; b < TF; b++) begin
      wait_frame();
      advance(1);
    end
    repeat (FC - 1) tick();
    cmd_valid = 1'b1;
    cmd_ch = 2'd1;
    cmd_pw = 17'd58000;
    tick();
    cmd_valid = 1'b0;
    advance(1);
    checks++; if (frame_start !== 1'b1 || state !== 2'd2) begin failures++; $display("FAIL timeout_cmd fs=%b state=%0d exp=1/2", frame_start, state); end
    checks++; if (failsafe !== 1'b0) begin failures++; $display("FAIL timeout_cmd_fs got=%b exp=0", failsafe); end
    wait_frame();
    advance(1);
    checks++; if (state !== 2'd2 || pw_bus !== pack_exp()) begin failures++; $display("FAIL timeout_after state=%0d pw=%h exp=2/%h", state, pw_bus, pack_exp()); end
  endtask

  task automatic test_reset_midramp();
    int n;
    send_cmd(1, 70000);
    run_frames(3, 1);
    checks++; if (pw_bus !== pack_exp()) begin failures++; $display("FAIL midramp_pre got=%h exp=%h", pw_bus, pack_exp()); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
    checks++; if (state !== 2'd0 || pw_bus !== 68'd0) begin failures++; $display("FAIL midrst state=%0d pw=%h exp=0/0", state, pw_bus); end
    checks++; if (frame_start !== 1'b0 || cmd_ready !== 1'b0 || failsafe !== 1'b0) begin failures++; $display("FAIL midrst_flags fs=%b rdy=%b flt=%b exp=0", frame_start, cmd_ready, failsafe); end
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < FC + 5);
    checks++; if (n !== FC) begin failures++; $display("FAIL midrst_phase got=%0d exp=%0d", n, FC); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arming();
    test_ramp();
    test_clamp();
    test_random();
    test_failsafe();
    test_simultaneous();
    test_reset_midramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
